// File: rtl/piso_cfg_shifter.sv
// piso_cfg_shifter: parallel-in/serial-out shifter feeding the FPGA configuration
// scan chain. Words arrive over valid/ready into a one-deep holding buffer, move
// into the shift register, and leave LSB first with sen_o qualifying each bit.
// A frame is a programmed number of words; done_o pulses once the last bit is out.
module piso_cfg_shifter #(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 8,
  parameter int WCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start_i,
  input  logic [WCNT_WIDTH-1:0] word_count_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  sdata_o,
  output logic                  sen_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_WIDTH-1:0]  LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [WCNT_WIDTH-1:0] ONE_WORD = WCNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  ONE_BIT  = CNT_WIDTH'(1);

  logic [1:0]            state_r;
  logic [1:0]            state_nx_s;
  logic [DATA_WIDTH-1:0] hold_r;
  logic [DATA_WIDTH-1:0] shreg_r;
  logic                  hold_full_r;
  logic                  sh_full_r;
  logic [CNT_WIDTH-1:0]  bitcnt_r;
  logic [WCNT_WIDTH-1:0] words_left_r;

  logic in_shift_s;
  logic shifting_s;
  logic last_bit_s;
  logic xfer_s;
  logic room_s;
  logic ready_s;
  logic hs_s;

  // Datapath qualifiers: shifting, last bit, hold->shreg transfer, frame room, handshake.
  always_comb begin
    in_shift_s = (state_r == ST_SHIFT);
    shifting_s = in_shift_s & sh_full_r & en;
    last_bit_s = shifting_s & (bitcnt_r == LAST_BIT);
    xfer_s     = in_shift_s & en & hold_full_r & (~sh_full_r | last_bit_s);
    // words_left counts words not yet fully sent; the word in shreg (if any) is
    // already accepted, so more may be taken only while words_left exceeds it.
    room_s     = (words_left_r > {{(WCNT_WIDTH-1){1'b0}}, sh_full_r});
    ready_s    = in_shift_s & ~hold_full_r & en & room_s;
    hs_s       = valid_i & ready_s;
  end

  // Frame sequencing: IDLE -> SHIFT (or straight to DONE for an empty frame) -> DONE -> IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (|word_count_i) begin
            state_nx_s = ST_SHIFT;
          end else begin
            state_nx_s = ST_DONE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s && (words_left_r == ONE_WORD)) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, buffers and counters; abort wins over everything, en=0 freezes all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      hold_r       <= '0;
      shreg_r      <= '0;
      hold_full_r  <= 1'b0;
      sh_full_r    <= 1'b0;
      bitcnt_r     <= '0;
      words_left_r <= '0;
    end else if (abort_i) begin
      state_r      <= ST_IDLE;
      hold_full_r  <= 1'b0;
      sh_full_r    <= 1'b0;
      bitcnt_r     <= '0;
      words_left_r <= '0;
    end else if (en) begin
      state_r <= state_nx_s;

      if ((state_r == ST_IDLE) && start_i) begin
        words_left_r <= word_count_i;
      end else if (last_bit_s) begin
        words_left_r <= words_left_r - ONE_WORD;
      end

      // A new handshake keeps the buffer full even when its old word moves on.
      if (hs_s) begin
        hold_r      <= data_i;
        hold_full_r <= 1'b1;
      end else if (xfer_s) begin
        hold_full_r <= 1'b0;
      end

      if (xfer_s) begin
        shreg_r   <= hold_r;
        sh_full_r <= 1'b1;
        bitcnt_r  <= '0;
      end else if (last_bit_s) begin
        shreg_r   <= shreg_r >> 1;
        sh_full_r <= 1'b0;
        bitcnt_r  <= '0;
      end else if (shifting_s) begin
        shreg_r  <= shreg_r >> 1;
        bitcnt_r <= bitcnt_r + ONE_BIT;
      end
    end
  end

  assign ready_o = ready_s;
  assign sen_o   = shifting_s;
  assign sdata_o = shifting_s & shreg_r[0];
  assign busy_o  = (state_r != ST_IDLE);
  assign done_o  = (state_r == ST_DONE) & en;

endmodule

// File: tb/tb_piso_cfg_shifter.sv
// tb_piso_cfg_shifter: self-checking bench for piso_cfg_shifter. A negedge
// monitor holds the expected serial stream as a bit queue filled from every
// accepted word; directed sequences check timing corners, a vector table checks
// whole frames and a randomized loop mixes valid and en.
module tb_piso_cfg_shifter;
  localparam int DW = 128;
  localparam int CW = 8;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b1;
  logic          start_i = 1'b0;
  logic [WW-1:0] word_count_i = '0;
  logic          abort_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o, sdata_o, sen_o, busy_o, done_o;

  piso_cfg_shifter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .WCNT_WIDTH(WW)) dut (
    .clk(clk), .rst(rst), .en(en), .start_i(start_i), .word_count_i(word_count_i),
    .abort_i(abort_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .sdata_o(sdata_o), .sen_o(sen_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad = 0;
  logic exp_q[$];
  int   frame_wc = 0, frame_acc = 0, sen_cnt = 0, runs = 0, done_cnt = 0;
  int   first_sen = -1, last_sen = -1, done_cyc = -1, sen128_cyc = -1, st_cyc = 0;
  bit   prev_sen = 1'b0, ready_seen = 1'b0;

  typedef struct {
    int wc;
    int gap;
    int exp_sen;
    int exp_done;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: track handshakes, compare every serial bit against the accepted words.
  always @(negedge clk) begin
    if (rst) begin
      if (ready_o) begin
        ready_seen = 1'b1;
        check("ready_beyond_frame", 128'(frame_acc >= frame_wc), 128'(0));
      end
      if (!en) check("en_off_quiet", 128'({sen_o, ready_o, sdata_o}), 128'(0));
      if (valid_i && ready_o && !abort_i) begin
        for (int i = 0; i < DW; i++) exp_q.push_back(data_i[i]);
        frame_acc++;
      end
      if (sen_o) begin
        if (sen_cnt == 0) first_sen = cyc;
        if (sen_cnt == 128) sen128_cyc = cyc;
        if (!prev_sen) runs++;
        if (exp_q.size() == 0) check("stream_extra_bit", 128'(1), 128'(0));
        else check("stream_bit", 128'(sdata_o), 128'(exp_q.pop_front()));
        sen_cnt++;
        last_sen = cyc;
      end else if (sdata_o) begin
        check("sdata_without_sen", 128'(sdata_o), 128'(0));
      end
      prev_sen = sen_o;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int wc);
    sync();
    frame_wc = wc; frame_acc = 0; sen_cnt = 0; runs = 0; done_cnt = 0;
    ready_seen = 1'b0; first_sen = -1; sen128_cyc = -1;
    st_cyc = cyc;
    start_i = 1'b1;
    word_count_i = WW'(wc);
    sync();
    start_i = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, output int hs_cyc);
    int t;
    sync();
    valid_i = 1'b1;
    data_i = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ready_o && t < 2000);
    check("send_accept_in_time", 128'(ready_o), 128'(1));
    hs_cyc = cyc;
    sync();
    valid_i = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int t;
    t = 0;
    while (done_cnt == 0 && t < limit) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("done_within_budget", 128'(done_cnt != 0), 128'(1));
  endtask

  task automatic wait_sen(input int n, input int limit);
    int t;
    t = 0;
    while (sen_cnt < n && t < limit) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("sen_count_reached", 128'(sen_cnt >= n), 128'(1));
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1);
  end

  // Main test sequence.
  initial begin
    logic [DW-1:0] w0, wa, wb;
    logic [DW-1:0] words[4];
    int n, nb, sent, cap, wc;
    bit gap_quiet;

    tbl[0] = '{wc: 1, gap: 0,  exp_sen: 128, exp_done: 1};
    tbl[1] = '{wc: 2, gap: 0,  exp_sen: 256, exp_done: 1};
    tbl[2] = '{wc: 3, gap: 7,  exp_sen: 384, exp_done: 1};
    tbl[3] = '{wc: 2, gap: 200, exp_sen: 256, exp_done: 1};

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check("reset_outputs", 128'({sdata_o, sen_o, ready_o, busy_o, done_o}), 128'(0));
    rst = 1'b1;

    // 1: single word, exact latency and done timing
    w0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    start_frame(1);
    check("t1_busy_after_start", 128'(busy_o), 128'(1));
    send_word(w0, n);
    wait_done(400);
    check("t1_first_bit_cycle", 128'(first_sen), 128'(n + 2));
    check("t1_last_bit_cycle", 128'(last_sen), 128'(n + 129));
    check("t1_sen_count", 128'(sen_cnt), 128'(128));
    check("t1_done_cycle", 128'(done_cyc), 128'(n + 130));
    check("t1_stream_consumed", 128'(exp_q.size()), 128'(0));
    @(negedge clk);
    check("t1_single_done", 128'(done_cnt), 128'(1));
    check("t1_idle_after", 128'(busy_o), 128'(0));

    // 2: back-to-back words, no bubble
    wa = rand_word(); wb = rand_word();
    start_frame(2);
    send_word(wa, n);
    send_word(wb, nb);
    @(negedge clk);
    check("t2_ready_low_after_second", 128'(ready_o), 128'(0));
    wait_done(600);
    check("t2_sen_count", 128'(sen_cnt), 128'(256));
    check("t2_one_run", 128'(runs), 128'(1));
    check("t2_done_after_last", 128'(done_cyc), 128'(last_sen + 1));
    @(negedge clk);
    check("t2_single_done", 128'(done_cnt), 128'(1));

    // 3: underrun gap between words
    wa = rand_word(); wb = rand_word();
    start_frame(2);
    send_word(wa, n);
    wait_sen(128, 400);
    gap_quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (sen_o) gap_quiet = 1'b0;
    end
    check("t3_gap_quiet", 128'(gap_quiet), 128'(1));
    send_word(wb, nb);
    wait_done(600);
    check("t3_resume_latency", 128'(sen128_cyc), 128'(nb + 2));
    check("t3_sen_count", 128'(sen_cnt), 128'(256));
    check("t3_two_runs", 128'(runs), 128'(2));
    check("t3_stream_consumed", 128'(exp_q.size()), 128'(0));

    // 4: en low for 5 cycles at bit 60
    w0 = rand_word();
    start_frame(1);
    send_word(w0, n);
    wait_sen(60, 400);
    sync();
    en = 1'b0;
    repeat (5) sync();
    check("t4_frozen_count", 128'(sen_cnt), 128'(60));
    en = 1'b1;
    wait_done(400);
    check("t4_sen_count", 128'(sen_cnt), 128'(128));
    check("t4_runs", 128'(runs), 128'(2));
    check("t4_stream_consumed", 128'(exp_q.size()), 128'(0));

    // 5: abort at bit 40 with the holding buffer full
    wa = rand_word(); wb = rand_word();
    start_frame(2);
    send_word(wa, n);
    send_word(wb, nb);
    wait_sen(40, 400);
    sync();
    abort_i = 1'b1;
    sync();
    abort_i = 1'b0;
    exp_q.delete();
    check("t5_after_abort", 128'({busy_o, sen_o, ready_o, done_o}), 128'(0));
    repeat (4) @(negedge clk);
    check("t5_no_done", 128'(done_cnt), 128'(0));
    w0 = rand_word();
    start_frame(1);
    send_word(w0, n);
    wait_done(400);
    check("t5_fresh_first_bit", 128'(first_sen), 128'(n + 2));
    check("t5_fresh_sen_count", 128'(sen_cnt), 128'(128));
    check("t5_stream_consumed", 128'(exp_q.size()), 128'(0));

    // 6a: empty frame
    start_frame(0);
    wait_done(10);
    check("t6_done_next_cycle", 128'(done_cyc), 128'(st_cyc + 1));
    check("t6_no_sen", 128'(sen_cnt), 128'(0));
    check("t6_ready_never", 128'(ready_seen), 128'(0));

    // 6b: asynchronous reset mid-word
    w0 = rand_word();
    start_frame(1);
    send_word(w0, n);
    wait_sen(20, 400);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_reset_outputs", 128'({sdata_o, sen_o, ready_o, busy_o, done_o}), 128'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_no_done_after_reset", 128'(done_cnt), 128'(0));
    check("t6_idle_after_reset", 128'(busy_o), 128'(0));

    // Vector table: whole frames with idle gaps before each word
    for (int v = 0; v < 4; v++) begin
      start_frame(tbl[v].wc);
      for (int k = 0; k < tbl[v].wc; k++) begin
        repeat (tbl[v].gap) sync();
        send_word(rand_word(), n);
      end
      wait_done(3000);
      @(negedge clk);
      check($sformatf("vec%0d_sen_count", v), 128'(sen_cnt), 128'(tbl[v].exp_sen));
      check($sformatf("vec%0d_done_count", v), 128'(done_cnt), 128'(tbl[v].exp_done));
      check($sformatf("vec%0d_consumed", v), 128'(exp_q.size()), 128'(0));
    end

    // Randomized frames: random valid and random en dropouts
    for (int f = 0; f < 6; f++) begin
      wc = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) words[k] = rand_word();
      start_frame(wc);
      sent = 0;
      cap = 0;
      while (done_cnt == 0 && cap < 5000) begin
        en = ($urandom_range(0, 9) != 0);
        if (sent < wc) begin
          valid_i = ($urandom_range(0, 2) != 0);
          data_i = words[sent];
        end else begin
          valid_i = 1'b0;
        end
        @(negedge clk);
        #1;
        if (frame_acc > sent) sent = frame_acc;
        sync();
        cap++;
      end
      en = 1'b1;
      valid_i = 1'b0;
      check($sformatf("rnd%0d_done_seen", f), 128'(done_cnt), 128'(1));
      check($sformatf("rnd%0d_sen_count", f), 128'(sen_cnt), 128'(wc * 128));
      check($sformatf("rnd%0d_consumed", f), 128'(exp_q.size()), 128'(0));
      check($sformatf("rnd%0d_done_after_bits", f), 128'(done_cyc > last_sen), 128'(1));
    end

    repeat (3) sync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_cfg_shifter.md
Name: piso_cfg_shifter

Overview:
Parallel-in/serial-out shifter in the PMU. It is the transmit counterpart of the SIPO.
- Accepts DATA_WIDTH-bit words (decrypted AES output or host data) over a valid/ready handshake.
- Streams each word bit-serially, LSB first, into the FPGA configuration scan chain.
- Has a 1-deep holding buffer in front of the shift register, so back-to-back words shift with no bubble.
- A frame is a programmed number of words, bounded by start_i and done_o.

Parameters:
DATA_WIDTH, 128, word width in bits (>=2)
CNT_WIDTH, 8, bit counter width; must satisfy 2**CNT_WIDTH >= DATA_WIDTH
WCNT_WIDTH, 16, frame word-count width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
en  input  1  global enable; 0 freezes all state
start_i  input  1  frame start pulse, honoured only in IDLE
word_count_i  input  WCNT_WIDTH  words in frame, sampled with start_i
abort_i  input  1  synchronous frame abort
data_i  input  DATA_WIDTH  parallel word
valid_i  input  1  data_i valid
ready_o  output  1  holding buffer can accept
sdata_o  output  1  serial bit to scan chain
sen_o  output  1  scan shift enable; sdata_o valid when 1
busy_o  output  1  frame in progress (state != IDLE)
done_o  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; hold, shreg, hold_full, sh_full, bitcnt, words_left all cleared.
  - Outputs: sdata_o=0, sen_o=0, ready_o=0, busy_o=0, done_o=0.
  - Reset mid-frame discards all data; no done_o is produced.
- States:
  - IDLE: start_i=1 with word_count_i!=0 -> SHIFT, words_left<=word_count_i. start_i=1 with word_count_i==0 -> DONE.
  - SHIFT: runs until the last bit of the last word -> DONE.
  - DONE: done_o=1 for exactly that cycle -> IDLE.
- ready_o = (state==SHIFT) & !hold_full & en. Handshake completes when valid_i & ready_o on a rising edge; hold<=data_i, hold_full<=1.
- ready_o is 0 once the accepted words (in hold, in shreg, or already sent) total words_left. Words beyond the frame are never accepted.
- Hold->shreg transfer on an edge when hold_full & (!sh_full | last bit of shreg this cycle).
  - bitcnt<=0 on transfer. hold_full clears unless a new handshake occurs in the same cycle; new-word handshake and transfer may coincide.
- Shifting: in SHIFT with sh_full & en:
  - sen_o=1, sdata_o=shreg[0] (combinational from shreg).
  - Each edge: shreg>>=1, bitcnt++.
  - bitcnt==DATA_WIDTH-1 is the last bit: words_left--, sh_full clears unless a transfer occurs.
- Latency: handshake in cycle N -> transfer at end of N+1 -> bit0 on sdata_o with sen_o=1 in cycle N+2.
- Back-to-back: if hold_full at the last bit of the current word (cycle M), bit0 of the next word appears in cycle M+1. sen_o stays continuously high.
- Underrun: sh_full=0 in SHIFT -> sen_o=0, sdata_o=0, bitcnt holds. Resumes per the latency rule above.
- Frame end: words_left reaches 0 on the last-bit edge -> DONE. done_o=1 in the cycle after the final sen_o bit.
- en=0: no state, counter or register change; sen_o=0, ready_o=0, sdata_o=0. done_o is held off until en=1.
- abort_i (any state, en irrelevant):
  - Next edge: state=IDLE, hold_full=0, sh_full=0, words_left=0, no done_o.
  - abort_i has priority over start_i and over the handshake.
- start_i outside IDLE is ignored.

Test Plan:
1. Reset, start_i with word_count_i=1, data_i=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 accepted in cycle N:
   - sen_o high in cycles N+2..N+129.
   - Captured serial stream LSB-first equals the word.
   - done_o=1 in cycle N+130 only; busy_o then 0.
2. word_count_i=2, second word presented while the first is shifting:
   - 256 consecutive sen_o=1 cycles, no gap.
   - ready_o=0 after the second accept.
   - Exactly one done_o pulse.
3. word_count_i=2, second valid_i delayed 10 cycles after the first word's last bit:
   - sen_o=0 for the gap; bitcnt is held.
   - Stream resumes 2 cycles after the handshake; both words are intact.
4. en=0 for 5 cycles at bit 60 of a word:
   - sen_o=0 throughout.
   - Resumes at bit 60; total of 128 sen_o cycles; data intact.
5. abort_i at bit 40 with hold_full=1:
   - Next cycle: IDLE, busy_o=0, sen_o=0, no done_o.
   - A new start_i/word_count_i=1 then sends a fresh word correctly.
6. start_i with word_count_i=0: done_o pulses the next cycle, no sen_o, ready_o stays 0. Async rst assertion mid-word: all outputs 0 immediately.
